// File: rtl/lutram_mport.sv
// Multi-port LUT RAM: one shared write port feeding NPORTS channels, each with its own read address, plus a CLR-triggered sweep that restores INIT.
// Optional LUTRAM_BYPASS_EN selects write-first read behaviour; the default is read-first.
module lutram_mport #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2,
  parameter int NPORTS = 8,
  parameter logic [NPORTS*DEPTH*WIDTH-1:0] INIT = '0,
  parameter bit IS_WCLK_INVERTED = 1'b0,
  parameter bit REG_OUT = 1'b0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     WCLK,
  input  logic                     RST,
  input  logic                     WE,
  input  logic [AW-1:0]            WADDR,
  input  logic [NPORTS*WIDTH-1:0]  DI,
  input  logic [NPORTS*AW-1:0]     RADDR,
  output logic [NPORTS*WIDTH-1:0]  DO,
  input  logic                     CLR,
  output logic                     BUSY,
  output logic                     WERR
);

  generate
    if (DEPTH != 32 && DEPTH != 64) begin : g_bad_depth
      $error("lutram_mport: DEPTH must be 32 or 64");
    end
    if (WIDTH < 1 || WIDTH > 4) begin : g_bad_width
      $error("lutram_mport: WIDTH must be in 1..4");
    end
    if (NPORTS < 1 || NPORTS > 8) begin : g_bad_nports
      $error("lutram_mport: NPORTS must be in 1..8");
    end
  endgenerate

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                          state, state_nxt;
  logic [AW-1:0]                   cnt, cnt_nxt;
  logic                            busy_q, busy_nxt;
  logic                            werr_q, werr_nxt;
  logic                            aclk;
  logic                            wr_acc;
  logic [NPORTS*WIDTH-1:0]         rd_p0;
  logic [NPORTS*WIDTH-1:0]         do_p1;
  // Flat storage so the power-up image is exactly INIT, same bit layout.
  logic [NPORTS*DEPTH*WIDTH-1:0]   mem = INIT;

  assign aclk   = WCLK ^ IS_WCLK_INVERTED;
  assign wr_acc = WE && (state == IDLE) && !RST;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    werr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (CLR) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        werr_nxt = WE;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == SWEEP);
  end

  always_ff @(posedge aclk or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      werr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
      werr_q <= werr_nxt;
    end
  end

  // Sweep writes take priority; user writes are only accepted in IDLE.
  always_ff @(posedge aclk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (state == SWEEP)
        mem[(p*DEPTH + int'(cnt))*WIDTH +: WIDTH] <= INIT[(p*DEPTH + int'(cnt))*WIDTH +: WIDTH];
      else if (wr_acc)
        mem[(p*DEPTH + int'(WADDR))*WIDTH +: WIDTH] <= DI[p*WIDTH +: WIDTH];
    end
  end

  // p0: combinational read per port
  always_comb begin
    rd_p0 = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rd_p0[p*WIDTH +: WIDTH] = mem[(p*DEPTH + int'(RADDR[p*AW +: AW]))*WIDTH +: WIDTH];
`ifdef LUTRAM_BYPASS_EN
      if (wr_acc && (RADDR[p*AW +: AW] == WADDR))
        rd_p0[p*WIDTH +: WIDTH] = DI[p*WIDTH +: WIDTH];
`endif
    end
  end

  // p1: optional output register
  always_ff @(posedge aclk or posedge RST) begin
    if (RST) do_p1 <= '0;
    else     do_p1 <= rd_p0;
  end

  assign DO   = REG_OUT ? do_p1 : rd_p0;
  assign BUSY = busy_q;
  assign WERR = werr_q;

endmodule

// File: tb/tb_lutram_mport.sv
// Bench for lutram_mport: combinational and registered-output instances share stimulus and
// are checked against an array model of the memory and the restore sweep.
module tb_lutram_mport;
  localparam int DEPTH = 32;
  localparam int W     = 2;
  localparam int NP    = 8;
  localparam int AW    = 5;
  localparam int DW    = NP*W;
  localparam int RAW   = NP*AW;
  localparam logic [NP*DEPTH*W-1:0] INIT_V = {16{32'h9E377DB9}};

  logic clk = 1'b0;
  logic rst, we, clr;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  di;
  logic [RAW-1:0] raddr;
  logic [DW-1:0]  do_c, do_r;
  logic busy_c, busy_r, werr_c, werr_r;

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0]  model [NP][DEPTH];
  bit            m_sweep;
  int            m_idx;
  bit            m_werr;
  logic [DW-1:0] m_do_r;

  lutram_mport #(.DEPTH(DEPTH), .WIDTH(W), .NPORTS(NP), .INIT(INIT_V),
                 .IS_WCLK_INVERTED(1'b0), .REG_OUT(1'b0)) dut_c (
    .WCLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .DI(di), .RADDR(raddr),
    .DO(do_c), .CLR(clr), .BUSY(busy_c), .WERR(werr_c));

  lutram_mport #(.DEPTH(DEPTH), .WIDTH(W), .NPORTS(NP), .INIT(INIT_V),
                 .IS_WCLK_INVERTED(1'b0), .REG_OUT(1'b1)) dut_r (
    .WCLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .DI(di), .RADDR(raddr),
    .DO(do_r), .CLR(clr), .BUSY(busy_r), .WERR(werr_r));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_word(int p, int a);
    return INIT_V[(p*DEPTH + a)*W +: W];
  endfunction

  function automatic logic [RAW-1:0] all_addr(logic [AW-1:0] a);
    logic [RAW-1:0] r;
    for (int p = 0; p < NP; p++) r[p*AW +: AW] = a;
    return r;
  endfunction

  // Expected combinational read for the current inputs and model contents.
  function automatic logic [DW-1:0] exp_comb();
    logic [DW-1:0] r;
    logic [AW-1:0] ra;
    for (int p = 0; p < NP; p++) begin
      ra = raddr[p*AW +: AW];
      r[p*W +: W] = model[p][ra];
`ifdef LUTRAM_BYPASS_EN
      if (we && !rst && !m_sweep && ra == waddr) r[p*W +: W] = di[p*W +: W];
`endif
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] init_row(int a);
    logic [DW-1:0] r;
    for (int p = 0; p < NP; p++) r[p*W +: W] = init_word(p, a);
    return r;
  endfunction

  // One clock edge: apply the memory rules to the model, then settle.
  task automatic tick();
    logic [DW-1:0] pre;
    pre = exp_comb();
    @(posedge clk);
    if (rst) begin
      m_do_r = '0;
      m_werr = 1'b0;
    end else begin
      m_do_r = pre;
      m_werr = we && m_sweep;
      if (m_sweep) begin
        for (int p = 0; p < NP; p++) model[p][m_idx] = init_word(p, m_idx);
        if (m_idx == DEPTH - 1) m_sweep = 1'b0;
        m_idx++;
      end else begin
        if (we) for (int p = 0; p < NP; p++) model[p][waddr] = di[p*W +: W];
        if (clr) begin
          m_sweep = 1'b1;
          m_idx = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; clr = 1'b0; waddr = '0; di = '0;
    raddr = '0; raddr[AW-1:0] = 5'd5;
    #1;
    n_chk++; if (do_c[1:0] !== 2'b11) $display("FAIL por_word5: got %b want 11", do_c[1:0]); else n_pass++;
    n_chk++; if (do_c !== exp_comb()) $display("FAIL por_ports: got %h want %h", do_c, exp_comb()); else n_pass++;
    we = 1'b1; waddr = 5'd5; di = '0;
    tick(); tick();
    n_chk++; if (busy_c !== 1'b0 || busy_r !== 1'b0) $display("FAIL rst_busy: got %b%b want 00", busy_c, busy_r); else n_pass++;
    n_chk++; if (werr_c !== 1'b0 || werr_r !== 1'b0) $display("FAIL rst_werr: got %b%b want 00", werr_c, werr_r); else n_pass++;
    n_chk++; if (do_r !== '0) $display("FAIL rst_do_reg: got %h want 0", do_r); else n_pass++;
    n_chk++; if (do_c[1:0] !== 2'b11) $display("FAIL rst_wr_blocked: got %b want 11", do_c[1:0]); else n_pass++;
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic test_write();
    raddr = all_addr(5'd7); waddr = 5'd7; di = 16'h5555; we = 1'b1;
    #1;
    n_chk++; if (do_c !== exp_comb()) $display("FAIL write_pre: got %h want %h", do_c, exp_comb()); else n_pass++;
    tick();
    n_chk++; if (do_c !== 16'h5555) $display("FAIL write_lat0: got %h want 5555", do_c); else n_pass++;
    n_chk++; if (do_r !== m_do_r) $display("FAIL write_reg_edge1: got %h want %h", do_r, m_do_r); else n_pass++;
    we = 1'b0;
    tick();
    n_chk++; if (do_r !== 16'h5555) $display("FAIL write_lat1: got %h want 5555", do_r); else n_pass++;
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    waddr = 5'd4; raddr = all_addr(5'd4); di = '0; we = 1'b1;
    tick();
    di = 16'hAAAA;
    #1;
`ifdef LUTRAM_BYPASS_EN
    want = 16'hAAAA;
`else
    want = 16'h0000;
`endif
    n_chk++; if (do_c !== want) $display("FAIL bypass_pre: got %h want %h", do_c, want); else n_pass++;
    tick();
    n_chk++; if (do_c !== 16'hAAAA) $display("FAIL bypass_post: got %h want aaaa", do_c); else n_pass++;
    we = 1'b0;
  endtask

  task automatic test_random_rw();
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      waddr = AW'($urandom);
      di = DW'($urandom);
      raddr = RAW'({$urandom, $urandom});
      if (i % 4 == 0) raddr[3*AW +: AW] = waddr;
      #1;
      n_chk++; if (do_c !== exp_comb()) $display("FAIL rnd_pre[%0d]: got %h want %h", i, do_c, exp_comb()); else n_pass++;
      tick();
      n_chk++; if (do_c !== exp_comb()) $display("FAIL rnd_post[%0d]: got %h want %h", i, do_c, exp_comb()); else n_pass++;
      n_chk++; if (do_r !== m_do_r) $display("FAIL rnd_reg[%0d]: got %h want %h", i, do_r, m_do_r); else n_pass++;
    end
    we = 1'b0;
  endtask

  task automatic test_sweep();
    int hi;
    // Write and CLR on the same edge: write lands, sweep starts.
    we = 1'b1; clr = 1'b1; waddr = AW'($urandom); di = DW'($urandom);
    raddr = all_addr(waddr);
    tick();
    n_chk++; if (do_c !== exp_comb()) $display("FAIL clr_we_write: got %h want %h", do_c, exp_comb()); else n_pass++;
    n_chk++; if (busy_c !== 1'b1 || busy_r !== 1'b1) $display("FAIL sweep_start: got %b%b want 11", busy_c, busy_r); else n_pass++;
    we = 1'b0; clr = 1'b0;
    hi = 1;
    for (int c = 0; c < 100; c++) begin
      if (!busy_c) break;
      clr = (c == 5);
      raddr = RAW'({$urandom, $urandom});
      #1;
      n_chk++; if (do_c !== exp_comb()) $display("FAIL sweep_rd_pre[%0d]: got %h want %h", c, do_c, exp_comb()); else n_pass++;
      tick();
      n_chk++; if (do_r !== m_do_r) $display("FAIL sweep_rd_reg[%0d]: got %h want %h", c, do_r, m_do_r); else n_pass++;
      n_chk++; if (busy_c !== m_sweep || busy_r !== m_sweep) $display("FAIL sweep_busy[%0d]: got %b%b want %b", c, busy_c, busy_r, m_sweep); else n_pass++;
      if (busy_c) hi++;
    end
    clr = 1'b0;
    n_chk++; if (hi !== 32) $display("FAIL sweep_len: got %0d want 32", hi); else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      raddr = all_addr(AW'(a));
      #1;
      n_chk++; if (do_c !== init_row(a)) $display("FAIL sweep_restored[%0d]: got %h want %h", a, do_c, init_row(a)); else n_pass++;
    end
  endtask

  task automatic test_werr();
    int hi;
    logic [DW-1:0] old;
    raddr = all_addr(5'd20);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    hi = 0;
    for (int s = 1; s < 60; s++) begin
      if (!busy_c) break;
      we = (s == 4);
      if (s == 4) begin
        waddr = 5'd20;
        for (int p = 0; p < NP; p++) di[p*W +: W] = ~model[p][20];
      end
      old = exp_comb();
      tick();
      n_chk++; if (werr_c !== m_werr || werr_r !== m_werr) $display("FAIL werr[%0d]: got %b%b want %b", s, werr_c, werr_r, m_werr); else n_pass++;
      if (werr_c) hi++;
      if (s == 4) begin
        n_chk++; if (do_c !== old) $display("FAIL werr_mem_kept: got %h want %h", do_c, old); else n_pass++;
      end
    end
    we = 1'b0;
    n_chk++; if (hi !== 1) $display("FAIL werr_pulses: got %0d want 1", hi); else n_pass++;
  endtask

  task automatic test_reset_sweep();
    logic [DW-1:0] want;
    for (int a = 0; a < DEPTH; a++) begin
      we = 1'b1; waddr = AW'(a); di = DW'($urandom);
      tick();
    end
    we = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    #1;
    rst = 1'b1;
    m_sweep = 1'b0; m_idx = 0; m_werr = 1'b0; m_do_r = '0;
    #1;
    n_chk++; if (busy_c !== 1'b0 || busy_r !== 1'b0) $display("FAIL rst_async_busy: got %b%b want 00", busy_c, busy_r); else n_pass++;
    n_chk++; if (do_r !== '0) $display("FAIL rst_async_do: got %h want 0", do_r); else n_pass++;
    we = 1'b1; waddr = 5'd15; di = DW'($urandom); raddr = all_addr(5'd15);
    #1;
    n_chk++; if (do_c !== exp_comb()) $display("FAIL rst_rd_pre: got %h want %h", do_c, exp_comb()); else n_pass++;
    tick();
    n_chk++; if (do_c !== exp_comb()) $display("FAIL rst_rd_post: got %h want %h", do_c, exp_comb()); else n_pass++;
    rst = 1'b0; we = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      raddr = all_addr(AW'(a));
      #1;
      if (a < 10) want = init_row(a);
      else for (int p = 0; p < NP; p++) want[p*W +: W] = model[p][a];
      n_chk++; if (do_c !== want) $display("FAIL partial_restore[%0d]: got %h want %h", a, do_c, want); else n_pass++;
    end
    tick();
    n_chk++; if (busy_c !== 1'b0) $display("FAIL busy_after_rst: got %b want 0", busy_c); else n_pass++;
  endtask

  initial begin
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < DEPTH; a++) model[p][a] = init_word(p, a);
    m_sweep = 1'b0; m_idx = 0; m_werr = 1'b0; m_do_r = '0;
    test_reset();
    test_write();
    test_bypass();
    test_random_rw();
    test_sweep();
    test_werr();
    test_reset_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
